// File: rtl/instr_queue_reg.sv
// instr_queue_reg: DEPTH-entry prefetch queue feeding the decode-stage
// instruction register. Fetch pushes, decode pops one word per unstalled
// cycle, flush discards everything, and a popped HALT word freezes the block.
// Optional build macro: INSTR_QUEUE_BYPASS_EN lets a push into an empty,
// unstalled queue load the instruction register directly on the same edge.
module instr_queue_reg #(
  parameter int          BITS       = 32,
  parameter int          DEPTH      = 4,
  parameter int          CNT_BITS   = $clog2(DEPTH + 1),
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0020,
  parameter logic [31:0] HALT_INSTR = 32'hFFFF_FFFF
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_fetch_valid,
  input  logic [BITS-1:0]     i_fetch_data,
  output logic                o_fetch_ready,
  input  logic                i_stall_pipe,
  input  logic                i_flush,
  output logic [BITS-1:0]     o_instr,
  output logic                o_instr_valid,
  output logic [5:0]          o_opcode,
  output logic [4:0]          o_rs,
  output logic [4:0]          o_rt,
  output logic [4:0]          o_rd,
  output logic [15:0]         o_imm,
  output logic [CNT_BITS-1:0] o_count,
  output logic                o_halted,
  output logic                o_drop_err
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {RUN = 1'b0, HALTED = 1'b1} state_t;

  state_t                r_state, w_state_nxt;
  logic [BITS-1:0]       r_mem [DEPTH];
  logic [PTR_W-1:0]      r_head, r_tail;
  logic [CNT_BITS-1:0]   r_count;
  logic [BITS-1:0]       r_instr;
  logic                  r_instr_valid;
  logic                  r_drop_err;

  logic                  w_run;
  logic                  w_ready;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_bypass;
  logic                  w_enq;
  logic                  w_issue;
  logic [BITS-1:0]       w_issue_word;
  logic                  w_halt_hit;

  // Handshake and issue decisions; ready depends on registered state only.
  always_comb begin
    w_run   = (r_state == RUN);
    w_ready = w_run && (r_count < CNT_BITS'(DEPTH));
    w_push  = i_fetch_valid && w_ready;
    w_pop   = w_run && !i_flush && !i_stall_pipe && (r_count != '0);
`ifdef INSTR_QUEUE_BYPASS_EN
    w_bypass = w_run && !i_flush && !i_stall_pipe && (r_count == '0) && w_push;
`else
    w_bypass = 1'b0;
`endif
    w_enq        = w_push && !i_flush && !w_bypass;
    w_issue      = w_pop || w_bypass;
    w_issue_word = w_bypass ? i_fetch_data : r_mem[r_head];
    w_halt_hit   = w_issue && (w_issue_word == BITS'(HALT_INSTR));
  end

  // Next-state logic: only an issued HALT word leaves RUN; reset is the sole exit.
  always_comb begin
    w_state_nxt = r_state;
    if (r_state == RUN && w_halt_hit) w_state_nxt = HALTED;
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= RUN;
    else       r_state <= w_state_nxt;
  end

  // Queue storage; contents are don't-care whenever count says empty.
  always_ff @(posedge i_clk) begin
    if (w_enq) r_mem[r_tail] <= i_fetch_data;
  end

  // Pointers, occupancy and the issued instruction register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_head        <= '0;
      r_tail        <= '0;
      r_count       <= '0;
      r_instr       <= BITS'(NOP_INSTR);
      r_instr_valid <= 1'b0;
    end else if (r_state == HALTED) begin
      // Frozen: queue stays empty, HALT word stays visible.
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_head        <= '0;
      r_tail        <= '0;
      r_count       <= '0;
      r_instr       <= BITS'(NOP_INSTR);
      r_instr_valid <= 1'b0;
    end else begin
      if (w_enq) r_tail <= r_tail + 1'b1;
      if (w_pop) r_head <= r_head + 1'b1;
      r_count <= r_count + CNT_BITS'(w_enq) - CNT_BITS'(w_pop);
      if (w_halt_hit) begin
        // Anything still queued (or pushed this edge) behind HALT is dropped.
        r_head  <= '0;
        r_tail  <= '0;
        r_count <= '0;
      end
      if (!i_stall_pipe) begin
        r_instr       <= w_issue ? w_issue_word : BITS'(NOP_INSTR);
        r_instr_valid <= w_issue;
      end
    end
  end

  // Sticky overflow flag: a push offered while running but not ready.
  always_ff @(posedge i_clk) begin
    if (i_rst)                                            r_drop_err <= 1'b0;
    else if (i_fetch_valid && !w_ready && w_run && !i_flush) r_drop_err <= 1'b1;
  end

  assign o_fetch_ready = w_ready;
  assign o_instr       = r_instr;
  assign o_instr_valid = r_instr_valid;
  assign o_opcode      = r_instr[31:26];
  assign o_rs          = r_instr[25:21];
  assign o_rt          = r_instr[20:16];
  assign o_rd          = r_instr[15:11];
  assign o_imm         = r_instr[15:0];
  assign o_count       = r_count;
  assign o_halted      = (r_state == HALTED);
  assign o_drop_err    = r_drop_err;

endmodule

// File: tb/tb_instr_queue_reg.sv
// Testbench for instr_queue_reg: directed scenarios plus randomized traffic,
// all compared against a queue-based reference model.
module tb_instr_queue_reg;
  localparam int          BITS  = 32;
  localparam int          DEPTH = 4;
  localparam int          CB    = $clog2(DEPTH + 1);
  localparam logic [31:0] NOP   = 32'h0000_0020;
  localparam logic [31:0] HALT  = 32'hFFFF_FFFF;

  logic            clk = 1'b0;
  logic            rst, fv, stall, flush;
  logic [BITS-1:0] fdata;
  logic            fready, ivalid, halted, drop_err;
  logic [BITS-1:0] instr;
  logic [5:0]      opcode;
  logic [4:0]      rs, rt, rd;
  logic [15:0]     imm;
  logic [CB-1:0]   count;

  int n_chk = 0;
  int n_err = 0;

  // reference model state
  logic [31:0] q[$];
  logic [31:0] m_instr;
  logic        m_valid, m_halt, m_drop;

  instr_queue_reg #(.BITS(BITS), .DEPTH(DEPTH)) dut (
    .i_clk(clk), .i_rst(rst), .i_fetch_valid(fv), .i_fetch_data(fdata),
    .o_fetch_ready(fready), .i_stall_pipe(stall), .i_flush(flush),
    .o_instr(instr), .o_instr_valid(ivalid), .o_opcode(opcode), .o_rs(rs),
    .o_rt(rt), .o_rd(rd), .o_imm(imm), .o_count(count), .o_halted(halted),
    .o_drop_err(drop_err));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance the model by one clock edge with the given inputs.
  task automatic model_edge(input logic r, input logic v, input logic [31:0] d,
                            input logic s, input logic f);
    logic rdy, push, byp;
    logic [31:0] w;
    logic iss;
    if (r) begin
      q.delete(); m_instr = NOP; m_valid = 0; m_halt = 0; m_drop = 0;
      return;
    end
    if (m_halt) return;
    rdy = (q.size() < DEPTH);
    if (v && !rdy && !f) m_drop = 1;
    if (f) begin
      q.delete(); m_instr = NOP; m_valid = 0;
      return;
    end
    push = v && rdy;
`ifdef INSTR_QUEUE_BYPASS_EN
    byp = push && !s && q.size() == 0;
`else
    byp = 0;
`endif
    iss = 0; w = NOP;
    if (!s) begin
      if (q.size() > 0) begin w = q.pop_front(); iss = 1; end
      else if (byp)     begin w = d; iss = 1; end
      m_instr = iss ? w : NOP;
      m_valid = iss;
    end
    if (push && !byp) q.push_back(d);
    if (iss && w == HALT) begin m_halt = 1; q.delete(); end
  endtask

  task automatic compare_all(input string tag);
    chk({tag, ".instr"},  instr, m_instr);
    chk({tag, ".valid"},  32'(ivalid), 32'(m_valid));
    chk({tag, ".count"},  32'(count), q.size());
    chk({tag, ".halted"}, 32'(halted), 32'(m_halt));
    chk({tag, ".drop"},   32'(drop_err), 32'(m_drop));
    chk({tag, ".ready"},  32'(fready), 32'(!m_halt && q.size() < DEPTH));
    chk({tag, ".fields"}, {opcode, rs, rt, rd, imm[10:0]},
        {m_instr[31:26], m_instr[25:21], m_instr[20:16], m_instr[15:11], m_instr[10:0]});
  endtask

  // Drive one cycle: inputs at negedge, check just after the posedge.
  task automatic step(input string tag, input logic r, input logic v,
                      input logic [31:0] d, input logic s, input logic f);
    @(negedge clk);
    rst = r; fv = v; fdata = d; stall = s; flush = f;
    model_edge(r, v, d, s, f);
    @(posedge clk); #1;
    compare_all(tag);
  endtask

  initial begin
    logic [31:0] w;
    rst = 1; fv = 0; fdata = '0; stall = 0; flush = 0;
    q.delete(); m_instr = NOP; m_valid = 0; m_halt = 0; m_drop = 0;

    // 1: reset values, then a single push issues
    step("rst", 1, 0, 0, 0, 0);
    chk("rst.instr_const", instr, NOP);
    chk("rst.ready_const", 32'(fready), 1);
    step("t1.push", 0, 1, 32'h0108_2020, 0, 0);
`ifndef INSTR_QUEUE_BYPASS_EN
    step("t1.pop", 0, 0, 0, 0, 0);
`endif
    chk("t1.issued", instr, 32'h0108_2020);
    chk("t1.count0", 32'(count), 0);

    // 2: fill while stalled, overflow push, then drain in order
    for (int i = 0; i < DEPTH; i++) step("t2.fill", 0, 1, 32'h1000 + i, 1, 0);
    chk("t2.full_ready", 32'(fready), 0);
    step("t2.ovf", 0, 1, 32'hDEAD, 1, 0);
    chk("t2.drop_set", 32'(drop_err), 1);
    for (int i = 0; i < DEPTH; i++) begin
      step("t2.drain", 0, 0, 0, 0, 0);
      chk("t2.order", instr, 32'h1000 + i);
    end

    // 3: flush with a same-cycle push
    step("t3.rst", 1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step("t3.fill", 0, 1, 32'h2000 + i, 1, 0);
    step("t3.flush", 0, 1, 32'hBEEF, 0, 1);
    chk("t3.flush_count", 32'(count), 0);
    chk("t3.flush_drop", 32'(drop_err), 0);
    step("t3.push", 0, 1, 32'h3333, 0, 0);
    step("t3.pop", 0, 0, 0, 0, 0);

    // 4: halt in the stream
    step("t4.a", 0, 1, 32'hA, 0, 0);
    step("t4.h", 0, 1, HALT, 0, 0);
    step("t4.b", 0, 1, 32'hB, 0, 0);
    step("t4.x", 0, 0, 0, 0, 0);
    chk("t4.halted", 32'(halted), 1);
    chk("t4.instr_halt", instr, HALT);
    step("t4.flush_ign", 0, 1, 32'hC, 0, 1);
    step("t4.rst", 1, 0, 0, 0, 0);
    chk("t4.unhalt", 32'(halted), 0);

    // 5: continuous streaming across pointer wrap
    for (int i = 0; i < 3 * DEPTH; i++) step("t5.stream", 0, 1, 32'h5000 + i, 0, 0);
    step("t5.tail", 0, 0, 0, 0, 0);
    chk("t5.last", instr, 32'h5000 + 3 * DEPTH - 1);

    // 6: reset while stalled with words queued
    for (int i = 0; i < 3; i++) step("t6.fill", 0, 1, 32'h6000 + i, 1, 0);
    step("t6.rst", 1, 0, 0, 1, 0);
    chk("t6.count0", 32'(count), 0);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      w = ($urandom_range(0, 15) == 0) ? HALT : $urandom;
      step("rand", $urandom_range(0, 63) == 0, $urandom_range(0, 9) < 7, w,
           $urandom_range(0, 2) == 0, $urandom_range(0, 15) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
